ltssm_substate_sequencer: RTL
=============================

// Module: ltssm_substate_sequencer
// PURPOSE
//   Top-level LTSSM sequencer for the PCIe logical PHY. Enables one substate controller at a time
//   (detect, polling, configuration, recovery) and walks DETECT->POLLING->CONFIG->L0 using their
//   success/error results. Muxes the four substate AXI-Stream TX outputs onto a single TX stream.
//   Substate switches happen only on packet boundaries.
// PARAMETERS
//   DATA_WIDTH      32        TX stream data width (bits)
//   KEEP_WIDTH      DATA_WIDTH/8  tkeep width
//   USER_WIDTH      5         tuser width
//   TIMEOUT_CYCLES  24000     cycles allowed per substate before timeout (>=2)
//   TIMER_WIDTH     $clog2(TIMEOUT_CYCLES+1)  timer counter width
// PORTS
//   clk_i              in   1              clock
//   rst_i              in   1              synchronous active-high reset
//   retrain_i          in   1              request retrain from L0 (level, sampled in L0 only)
//   restart_i          in   1              leave DISABLED, go to DETECT
//   sub_en_o           out  4              substate enables, one-hot or zero [0]=det [1]=pol [2]=cfg [3]=rec
//   sub_success_i      in   4              substate success, per index
//   sub_error_i        in   4              substate error, per index
//   cfg_error_disable_i  in 1              configuration requests Disabled
//   cfg_error_loopback_i in 1              configuration requests Loopback (unsupported)
//   state_o            out  3              0 DET,1 POL,2 CFG,3 L0,4 REC,5 DIS
//   link_up_o          out  1              high while state_o==L0
//   loopback_req_o     out  1              1-cycle pulse when loopback request is rejected
//   timeout_o          out  1              1-cycle pulse when substate timer expires
//   s_axis_tdata_i     in   4*DATA_WIDTH   substate TX data, slice i = substate i
//   s_axis_tkeep_i     in   4*KEEP_WIDTH   substate tkeep
//   s_axis_tvalid_i    in   4              substate tvalid
//   s_axis_tlast_i     in   4              substate tlast
//   s_axis_tuser_i     in   4*USER_WIDTH   substate tuser
//   s_axis_tready_o    out  4              substate tready
//   m_axis_tdata_o / tkeep_o / tvalid_o / tlast_o / tuser_o  out  muxed TX stream
//   m_axis_tready_i    in   1              downstream ready
// BEHAVIOUR
//   Reset: state=DET; timer=0; pkt_active=0; pending=0; all outputs 0.
//     sub_en_o=0001 is asserted one cycle after reset release.
//   FSM: result = sub_*_i[idx of state], sampled only while that enable is high.
//     DET:  success->POL; error|timeout->DET (restart).
//     POL:  success->CFG; error|timeout->DET.
//     CFG:  error_disable->DIS; error_loopback->DET with loopback_req_o pulse;
//           success->L0; error|timeout->DET.
//     L0:   retrain_i->REC. No timer.
//     REC:  success->L0; error->CFG; timeout->DET.
//     DIS:  restart_i->DET. No timer.
//   Priority when events coincide: error_disable > error_loopback > error > success > timeout.
//     retrain_i and restart_i are ignored outside L0 and DIS respectively.
//   Timer: cleared on every state entry; increments each cycle in DET/POL/CFG/REC.
//     Expires when value==TIMEOUT_CYCLES-1 (timeout_o pulses that cycle).
//   Transition timing: event at cycle N (pkt_active=0):
//     - N+1: state_o updated; sub_en_o=0 (one gap cycle so the substate reinitialises).
//     - N+2: new enable high. This also applies to DET->DET restart.
//     Entering L0 or DIS leaves sub_en_o=0.
//   Packet-boundary rule: pkt_active sets on a grant-source beat with tvalid&tready&!tlast,
//     and clears on tvalid&tready&tlast.
//     If an event occurs while pkt_active=1: latch pending target; keep old enable and grant.
//     Ignore further events and freeze the timer until the tlast beat is accepted.
//     Transition then proceeds as if the event had occurred on the tlast cycle.
//     rst_i mid-packet aborts immediately.
//   AXIS mux: grant = index of state (REC=3). In L0/DIS, and in the gap cycle, there is no grant:
//     m_axis_tvalid_o=0 and s_axis_tready_o=0.
//     m_axis_* = granted slice, combinational.
//     s_axis_tready_o[g] = m_axis_tready_i; non-granted tready=0.
//     No data is dropped or duplicated.
// TESTING
//   1. Release reset; pulse sub_success_i in order 0,1,2.
//      -> state_o 0->1->2->3; sub_en_o 0001,0000,0010,0000,0100,0000; link_up_o=1.
//   2. In POL, hold off success for 24000 cycles.
//      -> timeout_o pulse at cycle 23999; state_o=DET; sub_en_o 0000 then 0001.
//   3. In CFG, assert sub_success_i[2], cfg_error_disable_i and sub_error_i[2] together.
//      -> DIS; restart_i -> DET.
//   4. CFG with error_loopback -> loopback_req_o 1-cycle pulse; state DET.
//   5. Substate 2 sends 4-beat packet, success after beat 1, m_axis_tready_i toggling
//      -> all 4 beats forwarded in order; transition to L0 after beat 4 accepted.
//   6. L0, retrain_i=1 -> REC, sub_en_o=1000; sub_error_i[3] -> CFG; rst_i mid-run -> DET, outputs 0.

Source files
------------

// File: rtl/ltssm_substate_sequencer.sv
// LTSSM top-level sequencer: enables one substate controller at a time, walks
// DETECT->POLLING->CONFIG->L0 and muxes the substate TX streams on packet boundaries.
module ltssm_substate_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      retrain_i,
  input  logic                      restart_i,
  output logic [3:0]                sub_en_o,
  input  logic [3:0]                sub_success_i,
  input  logic [3:0]                sub_error_i,
  input  logic                      cfg_error_disable_i,
  input  logic                      cfg_error_loopback_i,
  output logic [2:0]                state_o,
  output logic                      link_up_o,
  output logic                      loopback_req_o,
  output logic                      timeout_o,
  input  logic [4*DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [4*KEEP_WIDTH-1:0]   s_axis_tkeep_i,
  input  logic [3:0]                s_axis_tvalid_i,
  input  logic [3:0]                s_axis_tlast_i,
  input  logic [4*USER_WIDTH-1:0]   s_axis_tuser_i,
  output logic [3:0]                s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]     m_axis_tkeep_o,
  output logic                      m_axis_tvalid_o,
  output logic                      m_axis_tlast_o,
  output logic [USER_WIDTH-1:0]     m_axis_tuser_o,
  input  logic                      m_axis_tready_i
);

  typedef enum logic [2:0] {
    ST_DET = 3'd0,
    ST_POL = 3'd1,
    ST_CFG = 3'd2,
    ST_L0  = 3'd3,
    ST_REC = 3'd4,
    ST_DIS = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 pend_target_r;
  state_t                 target_s;
  state_t                 commit_target_s;
  logic [3:0]             en_r;
  logic [TIMER_WIDTH-1:0] timer_r;
  logic                   pkt_active_r;
  logic                   pend_r;
  logic                   pend_lb_r;
  logic                   loopback_r;

  logic                   grant_valid_s;
  logic [1:0]             grant_idx_s;
  logic                   beat_s;
  logic                   pkt_next_s;
  logic                   succ_s;
  logic                   err_s;
  logic                   dis_s;
  logic                   lb_s;
  logic                   expire_s;
  logic                   event_s;
  logic                   lb_event_s;
  logic                   new_event_s;
  logic                   latch_s;
  logic                   commit_s;
  logic                   commit_lb_s;

  function automatic logic [3:0] state_enable(input state_t s);
    case (s)
      ST_DET:  return 4'b0001;
      ST_POL:  return 4'b0010;
      ST_CFG:  return 4'b0100;
      ST_REC:  return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic state_timed(input state_t s);
    case (s)
      ST_DET, ST_POL, ST_CFG, ST_REC: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Grant decode: the live enable selects the source; no enable means no grant.
  always_comb begin
    grant_valid_s = 1'b1;
    grant_idx_s   = 2'd0;
    case (en_r)
      4'b0001: grant_idx_s = 2'd0;
      4'b0010: grant_idx_s = 2'd1;
      4'b0100: grant_idx_s = 2'd2;
      4'b1000: grant_idx_s = 2'd3;
      default: grant_valid_s = 1'b0;
    endcase
  end

  assign m_axis_tdata_o  = grant_valid_s ? s_axis_tdata_i[grant_idx_s*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
  assign m_axis_tkeep_o  = grant_valid_s ? s_axis_tkeep_i[grant_idx_s*KEEP_WIDTH +: KEEP_WIDTH] : {KEEP_WIDTH{1'b0}};
  assign m_axis_tuser_o  = grant_valid_s ? s_axis_tuser_i[grant_idx_s*USER_WIDTH +: USER_WIDTH] : {USER_WIDTH{1'b0}};
  assign m_axis_tvalid_o = grant_valid_s & s_axis_tvalid_i[grant_idx_s];
  assign m_axis_tlast_o  = grant_valid_s & s_axis_tlast_i[grant_idx_s];
  assign s_axis_tready_o = en_r & {4{m_axis_tready_i}};

  assign beat_s     = m_axis_tvalid_o & m_axis_tready_i;
  assign pkt_next_s = beat_s ? ~m_axis_tlast_o : pkt_active_r;

  assign succ_s   = |(sub_success_i & en_r);
  assign err_s    = |(sub_error_i & en_r);
  assign dis_s    = en_r[2] & cfg_error_disable_i;
  assign lb_s     = en_r[2] & cfg_error_loopback_i;
  assign expire_s = state_timed(state_r) && (timer_r == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  // Next-state selection with priority disable > loopback > error > success > timeout.
  always_comb begin
    event_s    = 1'b0;
    lb_event_s = 1'b0;
    target_s   = state_r;
    case (state_r)
      ST_DET: begin
        if (err_s)         begin event_s = 1'b1; target_s = ST_DET; end
        else if (succ_s)   begin event_s = 1'b1; target_s = ST_POL; end
        else if (expire_s) begin event_s = 1'b1; target_s = ST_DET; end
        else               event_s = 1'b0;
      end
      ST_POL: begin
        if (err_s)         begin event_s = 1'b1; target_s = ST_DET; end
        else if (succ_s)   begin event_s = 1'b1; target_s = ST_CFG; end
        else if (expire_s) begin event_s = 1'b1; target_s = ST_DET; end
        else               event_s = 1'b0;
      end
      ST_CFG: begin
        if (dis_s)         begin event_s = 1'b1; target_s = ST_DIS; end
        else if (lb_s)     begin event_s = 1'b1; target_s = ST_DET; lb_event_s = 1'b1; end
        else if (err_s)    begin event_s = 1'b1; target_s = ST_DET; end
        else if (succ_s)   begin event_s = 1'b1; target_s = ST_L0;  end
        else if (expire_s) begin event_s = 1'b1; target_s = ST_DET; end
        else               event_s = 1'b0;
      end
      ST_L0: begin
        if (retrain_i) begin event_s = 1'b1; target_s = ST_REC; end
        else           event_s = 1'b0;
      end
      ST_REC: begin
        if (err_s)         begin event_s = 1'b1; target_s = ST_CFG; end
        else if (succ_s)   begin event_s = 1'b1; target_s = ST_L0;  end
        else if (expire_s) begin event_s = 1'b1; target_s = ST_DET; end
        else               event_s = 1'b0;
      end
      ST_DIS: begin
        if (restart_i) begin event_s = 1'b1; target_s = ST_DET; end
        else           event_s = 1'b0;
      end
      default: begin
        event_s  = 1'b1;
        target_s = ST_DET;
      end
    endcase
  end

  // A pending transition waits for the packet's tlast beat, then commits on that cycle.
  assign new_event_s     = event_s & ~pend_r;
  assign latch_s         = new_event_s & pkt_next_s;
  assign commit_s        = (new_event_s | pend_r) & ~pkt_next_s;
  assign commit_target_s = pend_r ? pend_target_r : target_s;
  assign commit_lb_s     = pend_r ? pend_lb_r : lb_event_s;
  assign timeout_o       = expire_s & ~pend_r;

  // State, enable, timer, packet tracking and pending-transition registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_DET;
      pend_target_r <= ST_DET;
      en_r          <= 4'b0000;
      timer_r       <= {TIMER_WIDTH{1'b0}};
      pkt_active_r  <= 1'b0;
      pend_r        <= 1'b0;
      pend_lb_r     <= 1'b0;
      loopback_r    <= 1'b0;
    end else begin
      pkt_active_r <= pkt_next_s;
      if (commit_s) begin
        state_r    <= commit_target_s;
        en_r       <= 4'b0000;
        timer_r    <= {TIMER_WIDTH{1'b0}};
        pend_r     <= 1'b0;
        pend_lb_r  <= 1'b0;
        loopback_r <= commit_lb_s;
      end else begin
        en_r       <= state_enable(state_r);
        loopback_r <= 1'b0;
        if (latch_s) begin
          pend_r        <= 1'b1;
          pend_target_r <= target_s;
          pend_lb_r     <= lb_event_s;
        end
        if (!(latch_s || pend_r)) begin
          timer_r <= state_timed(state_r) ? timer_r + TIMER_WIDTH'(1) : {TIMER_WIDTH{1'b0}};
        end
      end
    end
  end

  assign sub_en_o       = en_r;
  assign state_o        = state_r;
  assign link_up_o      = (state_r == ST_L0);
  assign loopback_req_o = loopback_r;

endmodule
